// File: rtl/nabp_angle_scheduler_pkg.sv
// Shared types and constants for the NABP angle scheduler and the shifter it drives.
package nabp_sched_pkg;

    localparam int unsigned DEF_ANGLE_WIDTH = 8;
    localparam int unsigned DEF_ACCU_WIDTH  = 16;

    // Accumulator base is unsigned Q8.8 (detector offset . sub-bin step), same as the shifter.
    localparam int unsigned ACCU_FRAC_BITS  = 8;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH      = 4'd1,
        ST_LATCH      = 4'd2,
        ST_FILL       = 4'd3,
        ST_FILL_WAIT  = 4'd4,
        ST_PE_WAIT    = 4'd5,
        ST_SHIFT      = 4'd6,
        ST_SHIFT_WAIT = 4'd7,
        ST_NEXT       = 4'd8,
        ST_DONE       = 4'd9
    } sched_state_t;

endpackage

// File: rtl/nabp_angle_scheduler.sv
// Steps the shifter through fill and shift passes for every projection angle of a run,
// fetching each angle's accumulator base from the angle ROM.
module nabp_angle_scheduler
    import nabp_sched_pkg::*;
#(
    parameter int unsigned NUM_ANGLES  = 180,
    parameter int unsigned ANGLE_WIDTH = DEF_ANGLE_WIDTH,
    parameter int unsigned ACCU_WIDTH  = DEF_ACCU_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   host_kick,
    input  logic                   host_abort,
    output logic                   host_busy,
    output logic                   host_done,
    output logic                   host_aborted,
    output logic                   err,
    output logic                   rom_en,
    output logic [ANGLE_WIDTH-1:0] rom_addr,
    input  logic [ACCU_WIDTH-1:0]  rom_data,
    output logic                   sh_fill_kick,
    output logic                   sh_shift_kick,
    output logic [ACCU_WIDTH-1:0]  sh_accu_base,
    input  logic                   sh_fill_done,
    input  logic                   sh_shift_done,
    input  logic                   pe_ready,
    output logic [ANGLE_WIDTH-1:0] cur_angle
);

    localparam logic [ANGLE_WIDTH-1:0] LAST_ANGLE = ANGLE_WIDTH'(NUM_ANGLES - 1);

    sched_state_t           state;
    logic [ANGLE_WIDTH-1:0] angle;
    logic                   abort_pend;
    logic                   aborted;

    assign rom_addr  = angle;
    assign cur_angle = angle;

    // Pulse outputs are registered on the transition into their state, so each one
    // is a pure function of the state register and never sees an input directly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            angle         <= '0;
            sh_accu_base  <= '0;
            abort_pend    <= 1'b0;
            aborted       <= 1'b0;
            err           <= 1'b0;
            host_busy     <= 1'b0;
            host_done     <= 1'b0;
            host_aborted  <= 1'b0;
            rom_en        <= 1'b0;
            sh_fill_kick  <= 1'b0;
            sh_shift_kick <= 1'b0;
        end else begin
            rom_en        <= 1'b0;
            sh_fill_kick  <= 1'b0;
            sh_shift_kick <= 1'b0;
            host_done     <= 1'b0;

            if (sh_fill_done && state != ST_FILL_WAIT) begin
                err <= 1'b1;
            end
            if (sh_shift_done && state != ST_SHIFT_WAIT) begin
                err <= 1'b1;
            end
            if (host_abort && state != ST_IDLE) begin
                abort_pend <= 1'b1;
                aborted    <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (host_kick) begin
                        state     <= ST_FETCH;
                        rom_en    <= 1'b1;
                        host_busy <= 1'b1;
                        aborted   <= 1'b0;
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    sh_accu_base <= rom_data;
                    sh_fill_kick <= 1'b1;
                    state        <= ST_FILL;
                end
                ST_FILL: state <= ST_FILL_WAIT;
                ST_FILL_WAIT: begin
                    if (sh_fill_done) begin
                        state <= ST_PE_WAIT;
                    end
                end
                ST_PE_WAIT: begin
                    if (pe_ready) begin
                        sh_shift_kick <= 1'b1;
                        state         <= ST_SHIFT;
                    end
                end
                ST_SHIFT: state <= ST_SHIFT_WAIT;
                ST_SHIFT_WAIT: begin
                    if (sh_shift_done) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // An abort arriving in this very cycle is honoured at the next boundary.
                    if (abort_pend || angle == LAST_ANGLE) begin
                        host_done    <= 1'b1;
                        host_aborted <= aborted | host_abort;
                        state        <= ST_DONE;
                    end else begin
                        angle  <= angle + ANGLE_WIDTH'(1);
                        rom_en <= 1'b1;
                        state  <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    angle        <= '0;
                    abort_pend   <= 1'b0;
                    host_aborted <= 1'b0;
                    host_busy    <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
